// File: rtl/lane_pkg.sv
// Shared types and constants for the lane_row slice: coordinate widths,
// divider width, lane/sink state encodings and the wrap-size helper.
package lane_pkg;

    localparam int COORD_W = 11;
    localparam int CALC_W  = 12;
    localparam int DIV_W   = 5;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CALC_W-1:0]  calc_t;

    typedef enum logic {
        LANE_INIT = 1'b0,
        LANE_RUN  = 1'b1
    } lane_state_t;

    typedef enum logic [1:0] {
        SINK_SURFACED  = 2'd0,
        SINK_SINKING   = 2'd1,
        SINK_SUBMERGED = 2'd2,
        SINK_RISING    = 2'd3
    } sink_state_t;

    // Offset space spans the screen plus one object so objects slide fully off-screen.
    function automatic calc_t wrap_size(input int obj_w, input int screen_w);
        return calc_t'(obj_w + screen_w);
    endfunction

endpackage

// File: rtl/lane_row_if.sv
// Controller-facing bus of one lane: control inputs, frog position, and the
// per-object coordinates / hit / carry outputs consumed by the colour mapper.
interface lane_row_if
    import lane_pkg::*;
#(
    parameter int MAX_OBJS = 6
);
    logic                Run;
    logic [3:0]          Number_Objs;
    logic [7:0]          Gap_Size;
    logic [DIV_W-1:0]    Speed;
    logic                Direction;
    coord_t              Row_Y;
    coord_t              Frog_X;
    coord_t              Frog_Y;
    coord_t              Obj_X [MAX_OBJS];
    coord_t              Obj_Y [MAX_OBJS];
    logic [MAX_OBJS-1:0] Obj_Active;
    logic                Row_Hit;
    logic                Carry_Pulse;
    logic                Carry_Dir;
    logic [1:0]          Sink_State;

    modport master (
        output Run, Number_Objs, Gap_Size, Speed, Direction, Row_Y, Frog_X, Frog_Y,
        input  Obj_X, Obj_Y, Obj_Active, Row_Hit, Carry_Pulse, Carry_Dir, Sink_State
    );

    modport slave (
        input  Run, Number_Objs, Gap_Size, Speed, Direction, Row_Y, Frog_X, Frog_Y,
        output Obj_X, Obj_Y, Obj_Active, Row_Hit, Carry_Pulse, Carry_Dir, Sink_State
    );

endinterface

// File: rtl/lane_wrap_step.sv
// Next X position of one object for a single step, wrapping seamlessly
// within the 0..WRAP-1 offset space in either direction.
module lane_wrap_step
    import lane_pkg::*;
#(
    parameter int OBJ_W    = 40,
    parameter int SCREEN_W = 640,
    parameter int STEP     = 4
) (
    input  coord_t x,
    input  logic   direction,
    output coord_t x_next
);

    localparam calc_t WRAP   = wrap_size(OBJ_W, SCREEN_W);
    localparam calc_t STEP_C = calc_t'(STEP);

    calc_t x_c;
    calc_t fwd;
    calc_t back;

    always_comb begin
        x_c = calc_t'(x);
        fwd = x_c + STEP_C;
        if (fwd >= WRAP) begin
            fwd = fwd - WRAP;
        end
        if (x_c < STEP_C) begin
            back = x_c + WRAP - STEP_C;
        end else begin
            back = x_c - STEP_C;
        end
        x_next = direction ? coord_t'(fwd) : coord_t'(back);
    end

endmodule

// File: rtl/lane_row.sv
// One horizontal lane of moving objects with spacing load, step divider,
// registered frog overlap and carry pulse. Optional sink cycle: LANE_SINK_EN.
module lane_row
    import lane_pkg::*;
#(
    parameter int MAX_OBJS    = 6,
    parameter int OBJ_W       = 40,
    parameter int ROW_H       = 32,
    parameter int FROG_W      = 32,
    parameter int SCREEN_W    = 640,
    parameter int STEP        = 4,
    parameter int SURF_FRAMES = 120,
    parameter int SUB_FRAMES  = 60
) (
    input  logic      frame_clk,
    input  logic      Reset,
    lane_row_if.slave bus
);

    localparam calc_t      WRAP  = wrap_size(OBJ_W, SCREEN_W);
    localparam logic [3:0] MAX_N = 4'(MAX_OBJS);

    lane_state_t         state;
    coord_t              obj_x     [MAX_OBJS];
    coord_t              obj_x_nxt [MAX_OBJS];
    logic [DIV_W-1:0]    div_cnt;
    logic [3:0]          n_active;
    logic [MAX_OBJS-1:0] active;
    logic [MAX_OBJS-1:0] hit_x;
    logic                y_overlap;
    logic                step;
    logic                submerged;
    logic                row_hit_vis;
    calc_t               frog_lo;
    calc_t               frog_hi;
    logic                row_hit_p1;
    logic                carry_pulse_p1;
    logic                carry_dir_p1;

    function automatic coord_t init_x(input int slot, input logic [7:0] gap);
        calc_t pos;
        pos = calc_t'(OBJ_W) + calc_t'(slot) * (calc_t'(gap) + calc_t'(OBJ_W));
        return coord_t'(pos % WRAP);
    endfunction

    // Frog box is shifted by OBJ_W so it lives in the same offset space as Obj_X.
    always_comb begin
        n_active  = (bus.Number_Objs > MAX_N) ? MAX_N : bus.Number_Objs;
        frog_lo   = calc_t'(bus.Frog_X) + calc_t'(OBJ_W);
        frog_hi   = frog_lo + calc_t'(FROG_W);
        y_overlap = (calc_t'(bus.Frog_Y) + calc_t'(FROG_W) > calc_t'(bus.Row_Y)) &&
                    (calc_t'(bus.Frog_Y) < calc_t'(bus.Row_Y) + calc_t'(ROW_H));
        active    = '0;
        hit_x     = '0;
        for (int i = 0; i < MAX_OBJS; i++) begin
            active[i] = 4'(i) < n_active;
            hit_x[i]  = active[i] &&
                        (frog_hi > calc_t'(obj_x[i])) &&
                        (frog_lo < calc_t'(obj_x[i]) + calc_t'(OBJ_W));
        end
    end

    assign step        = (state == LANE_RUN) && bus.Run && (div_cnt == bus.Speed);
    assign row_hit_vis = row_hit_p1 & ~submerged;

    for (genvar g = 0; g < MAX_OBJS; g++) begin : g_slot
        lane_wrap_step #(
            .OBJ_W    (OBJ_W),
            .SCREEN_W (SCREEN_W),
            .STEP     (STEP)
        ) u_step (
            .x         (obj_x[g]),
            .direction (bus.Direction),
            .x_next    (obj_x_nxt[g])
        );
        assign bus.Obj_X[g] = obj_x[g];
        assign bus.Obj_Y[g] = bus.Row_Y;
    end

    assign bus.Obj_Active = active;

    // Stage p1: overlap and carry registered; inactive slots still step to keep spacing.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state          <= LANE_INIT;
            div_cnt        <= '0;
            row_hit_p1     <= 1'b0;
            carry_pulse_p1 <= 1'b0;
            carry_dir_p1   <= 1'b0;
            for (int i = 0; i < MAX_OBJS; i++) begin
                obj_x[i] <= '0;
            end
        end else begin
            row_hit_p1     <= y_overlap && (|hit_x);
            carry_pulse_p1 <= 1'b0;
            case (state)
                LANE_INIT: begin
                    for (int i = 0; i < MAX_OBJS; i++) begin
                        obj_x[i] <= init_x(i, bus.Gap_Size);
                    end
                    state <= LANE_RUN;
                end
                LANE_RUN: begin
                    if (bus.Run) begin
                        if (div_cnt > bus.Speed) begin
                            div_cnt <= '0;
                        end else if (step) begin
                            div_cnt        <= '0;
                            carry_pulse_p1 <= row_hit_vis;
                            carry_dir_p1   <= bus.Direction;
                            for (int i = 0; i < MAX_OBJS; i++) begin
                                obj_x[i] <= obj_x_nxt[i];
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
                default: state <= LANE_INIT;
            endcase
        end
    end

    assign bus.Row_Hit     = row_hit_vis;
    assign bus.Carry_Pulse = carry_pulse_p1 & ~submerged;
    assign bus.Carry_Dir   = carry_dir_p1;

`ifdef LANE_SINK_EN
    localparam int SINK_BIG = (SURF_FRAMES > SUB_FRAMES) ? SURF_FRAMES : SUB_FRAMES;
    localparam int SINK_MAX = (SINK_BIG > 16) ? SINK_BIG : 16;
    localparam int SINK_CW  = $clog2(SINK_MAX);

    sink_state_t        sink_state;
    logic [SINK_CW-1:0] sink_cnt;

    function automatic logic [SINK_CW-1:0] sink_last(input sink_state_t s);
        case (s)
            SINK_SURFACED:  return SINK_CW'(SURF_FRAMES - 1);
            SINK_SUBMERGED: return SINK_CW'(SUB_FRAMES - 1);
            default:        return SINK_CW'(15);
        endcase
    endfunction

    // Sink cycle advances only on running frames, starting SURFACED after INIT.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            sink_state <= SINK_SURFACED;
            sink_cnt   <= '0;
        end else if ((state == LANE_RUN) && bus.Run) begin
            if (sink_cnt == sink_last(sink_state)) begin
                sink_cnt <= '0;
                case (sink_state)
                    SINK_SURFACED:  sink_state <= SINK_SINKING;
                    SINK_SINKING:   sink_state <= SINK_SUBMERGED;
                    SINK_SUBMERGED: sink_state <= SINK_RISING;
                    default:        sink_state <= SINK_SURFACED;
                endcase
            end else begin
                sink_cnt <= sink_cnt + 1'b1;
            end
        end
    end

    assign submerged      = (sink_state == SINK_SUBMERGED);
    assign bus.Sink_State = sink_state;
`else
    assign submerged      = 1'b0;
    assign bus.Sink_State = 2'(SINK_SURFACED);
`endif

endmodule

// File: doc/lane_row.md
Name: lane_row

Overview:
- Parametrised successor to the fixed four-pad lilypad row: one horizontal lane of up to MAX_OBJS moving objects (pads, logs, cars) in a single module.
- Object positions are held in internal registers, not per-object sub-instances.
- Provides power-on spacing load, step-rate divider and seamless wrap-around.
- Produces a registered frog-overlap flag and a frog "carry" pulse for rideable lanes. Sits between the game controller and the colour mapper.

Parameters:
- MAX_OBJS, 6: object slots instantiated (1..8).
- OBJ_W, 40: object width in pixels.
- ROW_H, 32: lane height in pixels.
- FROG_W, 32: frog box width/height.
- SCREEN_W, 640: visible width.
- STEP, 4: pixels moved per step.
- SURF_FRAMES, 120; SUB_FRAMES, 60: sink timing, used only with the optional feature.

Ports:
- frame_clk  in  1  frame-rate clock, sole clock
- Reset  in  1  asynchronous, active-high
- Run  in  1  1 = lane moves; 0 = freeze positions
- Number_Objs  in  4  active objects, 0..MAX_OBJS; larger values clamp to MAX_OBJS
- Gap_Size  in  8  pixels between consecutive objects
- Speed  in  5  step period = Speed+1 frames
- Direction  in  1  1 = right, 0 = left
- Row_Y  in  11  lane top Y
- Frog_X, Frog_Y  in  11 each  frog top-left
- Obj_X  out  MAX_OBJS x 11  offset X per object; screen left edge = Obj_X - OBJ_W
- Obj_Y  out  MAX_OBJS x 11  = Row_Y for every slot
- Obj_Active  out  MAX_OBJS  slot i active iff i < Number_Objs
- Row_Hit  out  1  registered frog/active-object overlap
- Carry_Pulse  out  1  one-frame pulse: lane stepped while Row_Hit
- Carry_Dir  out  1  Direction sampled with Carry_Pulse
- Sink_State  out  2  sink FSM state (0 when feature absent)

Behaviour:
- Clocking: the design is a single clock domain. Reset is asynchronous and active-high, on Reset.
- Reset values: state=INIT, all Obj_X=0, divider=0, Row_Hit=0, Carry_Pulse=0, Carry_Dir=0, Sink_State=0.
- Position arithmetic: coordinates run in offset space 0..WRAP-1 with WRAP = SCREEN_W + OBJ_W. All arithmetic is 12-bit internally; results are truncated to 11 bits.
- INIT state: the first frame_clk after Reset deasserts loads Obj_X[i] = (OBJ_W + i*(Gap_Size+OBJ_W)) mod WRAP, then goes to RUN. Spacing inputs are never used inside the async reset branch.
- Gap_Size changes in RUN have no effect until the next Reset.
- RUN divider: the counter increments each frame while Run=1. Step fires when counter == Speed; the counter then clears.
- Speed change: if Speed drops below the current count, the counter clears on the next frame and no step fires.
- Run=0: holds the counter and positions; Row_Hit keeps updating.
- Step, Direction=1: X' = X+STEP; if X' >= WRAP then X' -= WRAP.
- Step, Direction=0: if X < STEP then X' = X + WRAP - STEP, else X' = X - STEP.
- Step scope: all MAX_OBJS slots step, including inactive ones, so re-enabling a slot keeps spacing.
- Hit: (Frog_Y+FROG_W > Row_Y) and (Frog_Y < Row_Y+ROW_H) and, for some active i, (Frog_X+OBJ_W+FROG_W > Obj_X[i]) and (Frog_X+OBJ_W < Obj_X[i]+OBJ_W).
  - Comparison uses current-cycle positions; Row_Hit is registered, so it has 1 frame of latency.
  - Number_Objs=0 → Row_Hit is always 0.
- Carry: Carry_Pulse=1 on the frame after a step iff Row_Hit was 1 at that step; Carry_Dir=Direction at that step.
- Mid-operation Reset: asynchronously returns to INIT; outputs take reset values immediately.

Optional Feature:
- Macro: LANE_SINK_EN.
- When defined: a 4-state FSM runs only while Run=1.
  - SURFACED(0) holds SURF_FRAMES frames.
  - SINKING(1) holds 16 frames.
  - SUBMERGED(2) holds SUB_FRAMES frames.
  - RISING(3) holds 16 frames, then returns to SURFACED.
  - Row_Hit and Carry_Pulse are forced to 0 while in SUBMERGED.
  - The FSM enters SURFACED from INIT.
- When undefined: no FSM or counter logic; Sink_State tied to 0; hit behaviour unchanged.

Decomposition:
- Package lane_pkg:
  - WRAP and divider width constants.
  - typedef enum for sink states.
  - typedef for the 11-bit coordinate.
- One natural sub-module, lane_wrap_step: combinational next-X computation for one object (X, Direction → X'), instantiated per slot in a generate loop.

Test Plan:
- Reset release, Gap_Size=20, Number_Objs=3, defaults → after 1 frame Obj_X = {40,100,160,220,280,340}, Obj_Active=6'b000111.
- Speed=0, Direction=1, Obj_X[0]=676 → next frame 0; Speed=3 → one step every 4 frames exactly.
- Direction=0, Obj_X[0]=2 → next step 678; Run=0 for 10 frames → positions unchanged.
- Frog_X=50, Frog_Y=Row_Y, Obj_X[0]=100 (screen 60..99) → Row_Hit=1 one frame later. Number_Objs=0 → Row_Hit=0.
- Frog riding at step frame, Direction=1 → Carry_Pulse=1 for exactly 1 frame, Carry_Dir=1.
- LANE_SINK_EN defined, SURF_FRAMES=4, SUB_FRAMES=2 → Sink_State sequence 0x4,1x16,2x2,3x16. Row_Hit=0 during state 2 despite overlap. Reset mid-SUBMERGED → Sink_State=0.
